// File: rtl/mac_dot_pipe.sv
// Pipelined dot-product MAC: S1 operand reg, S2 product, S3 extended product, then accumulate/output.
// Define SAT_EN to clamp the accumulator on overflow instead of wrapping.
module mac_dot_pipe #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 24,
    parameter int DOT_LEN = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_signed,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_ovf
);

    localparam int PW    = 2 * DATA_W;
    localparam int CNT_W = (DOT_LEN > 1) ? $clog2(DOT_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DOT_LEN - 1);
    localparam logic [ACC_W-1:0] S_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] S_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mode_q, mode_d;
    logic [2:0]        vld_q, vld_d;

    logic [DATA_W-1:0] a1_q, a1_d, b1_q, b1_d;
    logic              mode1_q, mode1_d, last1_q, last1_d;
    logic [PW-1:0]     prod2_q, prod2_d;
    logic              mode2_q, mode2_d, last2_q, last2_d;
    logic [ACC_W-1:0]  prod3_q, prod3_d;
    logic              mode3_q, mode3_d, last3_q, last3_d;

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              sticky_q, sticky_d;
    logic              out_valid_q, out_valid_d;
    logic [ACC_W-1:0]  out_acc_q, out_acc_d;
    logic              out_ovf_q, out_ovf_d;

    logic              stall, accept, cur_mode, last_in;
    logic [PW-1:0]     a_ext, b_ext, prod_full;
    logic [ACC_W-1:0]  prod_ext, sum, acc_nxt;
    logic [ACC_W:0]    sum_full;
    logic              ovf_u, ovf_s, ovf;

    assign stall    = out_valid_q & ~out_ready;
    assign in_ready = ~stall & ~clr;
    assign accept   = in_valid & in_ready;

    // Mode is captured on the first element and held for the rest of the group.
    assign cur_mode = (cnt_q == '0) ? in_signed : mode_q;
    assign last_in  = (cnt_q == CNT_LAST);

    // Extending both operands to PW makes the low PW bits of one multiplier correct for either mode.
    assign a_ext     = {{DATA_W{mode1_q & a1_q[DATA_W-1]}}, a1_q};
    assign b_ext     = {{DATA_W{mode1_q & b1_q[DATA_W-1]}}, b1_q};
    assign prod_full = a_ext * b_ext;

    generate
        if (ACC_W > PW) begin : g_ext
            assign prod_ext = {{(ACC_W-PW){mode2_q & prod2_q[PW-1]}}, prod2_q};
        end else begin : g_noext
            assign prod_ext = prod2_q;
        end
    endgenerate

    assign sum_full = {1'b0, acc_q} + {1'b0, prod3_q};
    assign sum      = sum_full[ACC_W-1:0];
    assign ovf_u    = sum_full[ACC_W];
    assign ovf_s    = (acc_q[ACC_W-1] == prod3_q[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
    assign ovf      = mode3_q ? ovf_s : ovf_u;

`ifdef SAT_EN
    // A signed overflow always moves away from the accumulator's sign, so clamp toward it.
    assign acc_nxt = !ovf    ? sum :
                     mode3_q ? (acc_q[ACC_W-1] ? S_MIN : S_MAX) :
                               {ACC_W{1'b1}};
`else
    assign acc_nxt = sum;
`endif

    always_comb begin
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        vld_d       = vld_q;
        a1_d        = a1_q;
        b1_d        = b1_q;
        mode1_d     = mode1_q;
        last1_d     = last1_q;
        prod2_d     = prod2_q;
        mode2_d     = mode2_q;
        last2_d     = last2_q;
        prod3_d     = prod3_q;
        mode3_d     = mode3_q;
        last3_d     = last3_q;
        acc_d       = acc_q;
        sticky_d    = sticky_q;
        out_valid_d = out_valid_q;
        out_acc_d   = out_acc_q;
        out_ovf_d   = out_ovf_q;
        if (clr) begin
            cnt_d       = '0;
            vld_d       = '0;
            acc_d       = '0;
            sticky_d    = 1'b0;
            out_valid_d = 1'b0;
            out_ovf_d   = 1'b0;
        end else if (!stall) begin
            if (accept) begin
                cnt_d = last_in ? '0 : cnt_q + CNT_W'(1);
                if (cnt_q == '0) mode_d = in_signed;
            end
            vld_d   = {vld_q[1:0], accept};
            a1_d    = in_a;
            b1_d    = in_b;
            mode1_d = cur_mode;
            last1_d = last_in;
            prod2_d = prod_full;
            mode2_d = mode1_q;
            last2_d = last1_q;
            prod3_d = prod_ext;
            mode3_d = mode2_q;
            last3_d = last2_q;
            // Any held result was popped or absent, so out_valid tracks only a new arrival.
            out_valid_d = vld_q[2] & last3_q;
            if (vld_q[2]) begin
                if (last3_q) begin
                    out_acc_d = acc_nxt;
                    out_ovf_d = sticky_q | ovf;
                    acc_d     = '0;
                    sticky_d  = 1'b0;
                end else begin
                    acc_d    = acc_nxt;
                    sticky_d = sticky_q | ovf;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            vld_q       <= '0;
            a1_q        <= '0;
            b1_q        <= '0;
            mode1_q     <= 1'b0;
            last1_q     <= 1'b0;
            prod2_q     <= '0;
            mode2_q     <= 1'b0;
            last2_q     <= 1'b0;
            prod3_q     <= '0;
            mode3_q     <= 1'b0;
            last3_q     <= 1'b0;
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            vld_q       <= vld_d;
            a1_q        <= a1_d;
            b1_q        <= b1_d;
            mode1_q     <= mode1_d;
            last1_q     <= last1_d;
            prod2_q     <= prod2_d;
            mode2_q     <= mode2_d;
            last2_q     <= last2_d;
            prod3_q     <= prod3_d;
            mode3_q     <= mode3_d;
            last3_q     <= last3_d;
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mac_dot_pipe.sv
// Directed plus randomized bench for mac_dot_pipe; expected results come from an arithmetic group model.
module tb_mac_dot_pipe;
    localparam int DW = 8;
    localparam int AW = 16;
    localparam int DL = 4;

    logic          clk = 1'b0;
    logic          rst, clr, in_valid, in_ready, in_signed, out_valid, out_ready, out_ovf;
    logic [DW-1:0] in_a, in_b;
    logic [AW-1:0] out_acc;

    int     n_vec = 0;
    int     n_err = 0;
    bit     bp_rand = 1'b0;
    int     last_wait;
    longint exp_q[$];
    bit     ovf_q[$];
    longint gacc = 0;
    bit     govf = 1'b0;
    bit     gmode = 1'b0;
    int     gcnt = 0;

    mac_dot_pipe #(.DATA_W(DW), .ACC_W(AW), .DOT_LEN(DL)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_flush();
        exp_q.delete();
        ovf_q.delete();
        gacc = 0;
        govf = 1'b0;
        gcnt = 0;
    endtask

    // Group sum in plain integer arithmetic, range-checked against the result width.
    task automatic model_push(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s);
        longint p, sm, lo, hi, m;
        if (gcnt == 0) gmode = s;
        if (gmode) p = longint'($signed(a)) * longint'($signed(b));
        else       p = longint'(a) * longint'(b);
        m  = longint'(1) << AW;
        lo = gmode ? -(m / 2) : 0;
        hi = gmode ? (m / 2 - 1) : (m - 1);
        sm = gacc + p;
        if (sm > hi || sm < lo) begin
            govf = 1'b1;
`ifdef SAT_EN
            sm = (sm > hi) ? hi : lo;
`else
            sm = (sm - lo) % m;
            if (sm < 0) sm += m;
            sm += lo;
`endif
        end
        gacc = sm;
        gcnt++;
        if (gcnt == DL) begin
            exp_q.push_back(gacc & (m - 1));
            ovf_q.push_back(govf);
            gacc = 0;
            govf = 1'b0;
            gcnt = 0;
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic s);
        int g = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_signed = s;
        if (bp_rand) out_ready = 1'($urandom % 2);
        #1;
        while (!in_ready && g < 200) begin
            @(negedge clk);
            if (bp_rand) out_ready = 1'($urandom % 2);
            #1;
            g++;
        end
        last_wait = g;
        chk("accept", 32'(in_ready), 32'd1);
        if (in_ready) model_push(a, b, s);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: a result held with out_ready high is consumed at the next rising edge.
    always @(negedge clk) begin
        #2;
        if (out_valid && out_ready && !rst) begin
            if (exp_q.size() == 0) chk("unexpected_result", 32'(exp_q.size()), 32'd1);
            else begin
                chk("out_acc", 32'(out_acc), 32'(exp_q[0]));
                chk("out_ovf", 32'(out_ovf), 32'(ovf_q[0]));
                void'(exp_q.pop_front());
                void'(ovf_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] sa [4];
        logic [DW-1:0] sb [4];
        logic [AW-1:0] ovf_exp;
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_acc", 32'(out_acc), 32'd0);
        chk("rst_out_ovf", 32'(out_ovf), 32'd0);
        rst = 1'b0;
        #1 chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Signed group with exact latency: result visible after the third edge past the last accept.
        sa = '{8'hFD, 8'd7, 8'h80, 8'd127};
        sb = '{8'd5, 8'd7, 8'h80, 8'hFF};
        for (int i = 0; i < 4; i++) send(sa[i], sb[i], 1'b1);
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) @(negedge clk);
            #1 chk("latency_valid", 32'(out_valid), 32'(k == 3));
        end
        chk("signed_acc", 32'(out_acc), 32'h3FA3);
        chk("signed_ovf", 32'(out_ovf), 32'd0);
        drain();

        // Unsigned groups back to back; in_signed toggled mid-group must be ignored.
        for (int grp = 0; grp < 2; grp++)
            for (int i = 0; i < 4; i++) begin
                send(8'd255, 8'd255, (i == 0) ? 1'b0 : 1'b1);
                chk("no_bubble", 32'(last_wait), 32'd0);
            end
        drain();

        // Backpressure: first result holds, pipeline freezes, nothing is lost.
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) send(8'd1, 8'd1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_acc", 32'(out_acc), 32'd4);
            @(negedge clk);
        end
        out_ready = 1'b1;
        send(8'd1, 8'd1, 1'b0);
        drain();

        // Signed overflow.
`ifdef SAT_EN
        ovf_exp = 16'h7FFF;
`else
        ovf_exp = 16'h0000;
`endif
        for (int i = 0; i < 4; i++) send(8'h80, 8'h80, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        chk("ovf_valid", 32'(out_valid), 32'd1);
        chk("ovf_acc", 32'(out_acc), 32'(ovf_exp));
        chk("ovf_flag", 32'(out_ovf), 32'd1);
        drain();

        // Mid-group clear discards the partial group; a pair offered during clear is refused.
        send(8'd9, 8'd9, 1'b0);
        send(8'd9, 8'd9, 1'b0);
        clr = 1'b1; in_valid = 1'b1; in_a = 8'd7; in_b = 8'd7;
        model_flush();
        #1 chk("clr_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        clr = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 4; i++) send(8'd1, 8'd1, 1'b0);
        drain();

        // Randomized groups with random backpressure.
        bp_rand = 1'b1;
        for (int grp = 0; grp < 12; grp++) begin
            logic s;
            s = 1'($urandom % 2);
            for (int i = 0; i < 4; i++) send(8'($urandom), 8'($urandom), s);
        end
        bp_rand = 1'b0;
        drain();

        // Asynchronous reset while a result is held.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'd100, 8'd3, 1'b0);
        repeat (3) @(negedge clk);
        #1 chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        model_flush();
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_acc", 32'(out_acc), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) send(8'd2, 8'd3, 1'b0);
        repeat (3) @(negedge clk);
        #1 chk("post_rst_acc", 32'(out_acc), 32'd24);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
